// File: rtl/median_pixel_packer.sv
// Packs 1-bit median-filter results into bytes of 8 adjacent pixels and streams them out through a small FIFO.
// Optional PACKER_ONES_COUNT_EN adds a saturating count of accepted 1-pixels.
module median_pixel_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter bit FILL_BIT   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        writeEnable,
  input  logic        pixelIn,
  input  logic [7:0]  xMedianAddress,
  input  logic [7:0]  yMedianAddress,
  input  logic        filterDone,
  output logic [7:0]  byteOut,
  output logic [4:0]  byteCol,
  output logic [7:0]  byteRow,
  output logic        byteValid,
  input  logic        byteReady,
  output logic        overflow,
  output logic        frameDone
`ifdef PACKER_ONES_COUNT_EN
  ,
  output logic [15:0] onesCount
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [7:0]    FILL_BYTE = {8{FILL_BIT}};

  logic [7:0]  acc_byte;
  logic [4:0]  acc_col;
  logic [7:0]  acc_row;
  logic        acc_busy;
  logic        flush_next;
  logic        done_seen;
  logic        filter_done_d;

  logic [20:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;

  logic        cur_busy;
  logic        flush_req;
  logic        key_hit;
  logic        chain_flush;
  logic        done_rise;
  logic [7:0]  nxt_byte;
  logic [4:0]  nxt_col;
  logic [7:0]  nxt_row;
  logic        nxt_busy;
  logic        nxt_flush_next;
  logic        push;
  logic [20:0] push_data;
  logic        pop;
  logic        full;
  logic        push_ok;
  logic        drop;
  logic        frame_cond;

  // Accumulator update: start discards first, then at most one byte is flushed per cycle;
  // a second flush that would be needed in the same cycle is deferred via flush_next.
  always_comb begin
    cur_busy    = acc_busy && !start;
    flush_req   = flush_next && !start;
    done_rise   = filterDone && !filter_done_d;
    key_hit     = cur_busy && (yMedianAddress == acc_row) && (xMedianAddress[7:3] == acc_col);
    nxt_byte    = acc_byte;
    nxt_col     = acc_col;
    nxt_row     = acc_row;
    nxt_busy    = cur_busy;
    push        = 1'b0;
    push_data   = '0;
    chain_flush = 1'b0;
    if (writeEnable) begin
      if (cur_busy && !key_hit) begin
        push      = 1'b1;
        push_data = {acc_row, acc_col, acc_byte};
      end
      if (!key_hit) begin
        nxt_byte = FILL_BYTE;
        nxt_col  = xMedianAddress[7:3];
        nxt_row  = yMedianAddress;
      end
      nxt_byte[xMedianAddress[2:0]] = pixelIn;
      nxt_busy = 1'b1;
      if (xMedianAddress[2:0] == 3'd7) begin
        if (push) begin
          chain_flush = 1'b1;
        end else begin
          push      = 1'b1;
          push_data = {nxt_row, nxt_col, nxt_byte};
          nxt_busy  = 1'b0;
        end
      end
    end
    if (!push && flush_req && nxt_busy) begin
      push      = 1'b1;
      push_data = {nxt_row, nxt_col, nxt_byte};
      nxt_busy  = 1'b0;
    end
    nxt_flush_next = nxt_busy && (chain_flush || done_rise || flush_req);
  end

  always_comb begin
    pop     = byteValid && byteReady;
    full    = (count == CNT_FULL);
    push_ok = push && (!full || pop);
    drop    = push && !push_ok;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
    frame_cond = done_seen && !acc_busy && !flush_next && (count == '0)
                 && !push && !writeEnable && !start;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // The output registers always hold the FIFO head so the stream is first-word-fall-through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_byte      <= FILL_BYTE;
      acc_col       <= '0;
      acc_row       <= '0;
      acc_busy      <= 1'b0;
      flush_next    <= 1'b0;
      done_seen     <= 1'b0;
      filter_done_d <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      byteValid     <= 1'b0;
      byteOut       <= '0;
      byteCol       <= '0;
      byteRow       <= '0;
      overflow      <= 1'b0;
      frameDone     <= 1'b0;
    end else begin
      acc_byte      <= nxt_byte;
      acc_col       <= nxt_col;
      acc_row       <= nxt_row;
      acc_busy      <= nxt_busy;
      flush_next    <= nxt_flush_next;
      filter_done_d <= filterDone;
      frameDone     <= frame_cond;
      if (done_rise)                done_seen <= 1'b1;
      else if (start || frame_cond) done_seen <= 1'b0;
      if (drop)       overflow <= 1'b1;
      else if (start) overflow <= 1'b0;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      if (count_nxt == '0) begin
        byteValid <= 1'b0;
      end else begin
        byteValid <= 1'b1;
        if ((count == '0) || (pop && (count == CNT_ONE)))
          {byteRow, byteCol, byteOut} <= push_data;
        else if (pop)
          {byteRow, byteCol, byteOut} <= mem[rd_ptr + PTR_ONE];
      end
    end
  end

`ifdef PACKER_ONES_COUNT_EN
  logic [15:0] ones_base;
  logic [15:0] ones_nxt;

  always_comb begin
    ones_base = start ? 16'h0000 : onesCount;
    ones_nxt  = ones_base;
    if (writeEnable && pixelIn && (ones_base != 16'hFFFF))
      ones_nxt = ones_base + 16'h0001;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) onesCount <= '0;
    else        onesCount <= ones_nxt;
  end
`endif

endmodule

// File: doc/median_pixel_packer.md
Name: median_pixel_packer

Overview:
Sink for the median filter's result-write interface (writeEnable, dataOut, xMedianAddress, yMedianAddress, filterDone). It packs 1-bit filtered pixels into bytes, 8 horizontally adjacent pixels per byte. Bytes are buffered in a small FIFO and emitted over a valid/ready byte stream for host readout (UART/DMA). It signals frame completion once every result has drained.

Parameters:
FIFO_DEPTH, 8, number of byte entries buffered; power of two, minimum 2.
FILL_BIT, 0, value placed in byte bits whose pixel was never written (border pixels).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse at frame start; clears sticky status
writeEnable  input  1  filter result-pixel strobe
pixelIn  input  1  filtered pixel value (filter dataOut)
xMedianAddress  input  8  result pixel column
yMedianAddress  input  8  result pixel row
filterDone  input  1  filter end-of-frame indication (level or pulse; rising edge used)
byteOut  output  8  packed pixels; bit i = column {byteCol,i}
byteCol  output  5  byte column (x[7:3]) of byteOut
byteRow  output  8  row of byteOut
byteValid  output  1  byteOut/byteCol/byteRow valid
byteReady  input  1  downstream accepts the byte when byteValid && byteReady
overflow  output  1  sticky: a byte was dropped because the FIFO was full
frameDone  output  1  one-cycle pulse: frame fully packed and drained

Behaviour:
- Reset (reset=0, async): accumulator empty with bits = FILL_BIT; FIFO empty; byteValid=0; byteOut/byteCol/byteRow=0; overflow=0; frameDone=0; doneSeen=0.
- Accumulator holds accByte[7:0], accCol[4:0], accRow[7:0], accBusy.
- Pixel accept (writeEnable=1): target key = {y, x[7:3]}.
  - If accBusy and key differs from {accRow,accCol}: flush old accumulator, then load new key with bits=FILL_BIT except bit x[2:0]=pixelIn. One cycle.
  - Otherwise set bit x[2:0]=pixelIn and set accBusy. Rewriting the same x overwrites that bit.
  - If x[2:0]==7: flush the accumulator including this bit in the same cycle; accBusy=0 afterwards.
- filterDone rising edge: set doneSeen. If accBusy, flush the next cycle (after any same-cycle pixel is merged).
- Flush: push {accRow,accCol,accByte} into FIFO. If FIFO full and no pop this cycle: drop the byte and set overflow. Push while full with a simultaneous pop is allowed.
- FIFO: first-word-fall-through, registered outputs. Byte flushed in cycle N with FIFO empty appears with byteValid=1 in cycle N+1.
- byteValid stays high and byteOut/byteCol/byteRow stay stable until accepted. Pop occurs on byteValid && byteReady.
- Frame end: when doneSeen && !accBusy && FIFO empty && no push pending, pulse frameDone for 1 cycle, then clear doneSeen.
- start: clears overflow and doneSeen. Does not flush data already in the FIFO. Accumulator contents are discarded (accBusy=0).
- Simultaneous start and writeEnable: start clears first, then the pixel is accepted into a fresh accumulator.
- No back-pressure to the filter exists. Loss is reported only via overflow.
- Row wrap: a y change always flushes, even if the column field matches.

Optional Feature:
PACKER_ONES_COUNT_EN
- Defined: adds output onesCount[15:0], a count of accepted pixels with pixelIn=1 since the last start.
  - Saturates at 16'hFFFF.
  - Reset and start clear it to 0.
  - Rewriting an already-written position counts again; counting is raw, not deduplicated.
- Not defined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Write x=0..7, y=3, pixels 1,0,1,1,0,0,1,0, byteReady=1 -> one byte, byteOut=8'h4D, byteCol=0, byteRow=3, byteValid 1 cycle after the x=7 write.
- Write x=1..6 on y=0 with all 1, then x=8 y=0 pixel 1 (FILL_BIT=0) -> bytes 8'h7E (col 0) then, after filterDone, 8'h01 (col 1); frameDone pulses after the last pop.
- byteReady=0, write 9 full bytes (72 pixels, FIFO_DEPTH=8) -> overflow=1, first 8 bytes retained intact; start -> overflow=0.
- Full FIFO with byteReady=1 in the same cycle as a flush -> no drop, overflow stays 0, byte order preserved.
- writeEnable and filterDone in the same cycle at x=2 -> partial byte flushed (bit 2 set), frameDone only after that byte is accepted.
- Assert reset mid-frame with 3 bytes queued -> byteValid=0 immediately; no stale bytes after release. With PACKER_ONES_COUNT_EN, onesCount=0.
